// File: rtl/banco_escritura_if.sv
// rtl/banco_escritura_if.sv - write-side bus of the eight-entry register bank
// Groups the write, burst and readback signals; clk and rst_n stay plain ports.
interface banco_escritura_if #(
  parameter int WIDTH = 16
);
  logic             clr;
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             burst_start;
  logic [2:0]       burst_addr;
  logic [2:0]       burst_len;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] q0;
  logic [WIDTH-1:0] q1;
  logic [WIDTH-1:0] q2;
  logic [WIDTH-1:0] q3;
  logic [WIDTH-1:0] q4;
  logic [WIDTH-1:0] q5;
  logic [WIDTH-1:0] q6;
  logic [WIDTH-1:0] q7;
  logic             busy;
  logic             burst_done;

  modport master (
    output clr, wr_en, wr_addr, wr_data,
    output burst_start, burst_addr, burst_len, in_valid, in_data,
    input  q0, q1, q2, q3, q4, q5, q6, q7, busy, burst_done
  );

  modport slave (
    input  clr, wr_en, wr_addr, wr_data,
    input  burst_start, burst_addr, burst_len, in_valid, in_data,
    output q0, q1, q2, q3, q4, q5, q6, q7, busy, burst_done
  );
endinterface

// File: rtl/banco_escritura.sv
// rtl/banco_escritura.sv - eight-entry register storage with single and burst writes
// All outputs come straight from flops; the read mux consumes q0..q7 directly.
module banco_escritura #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  banco_escritura_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             ptr_q, ptr_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0][WIDTH-1:0]  regs_q, regs_d;
  logic                   done_q, done_d;

  // State register: asynchronous reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      cnt_q   <= 3'd0;
      regs_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
      done_q  <= done_d;
    end
  end

  // Next-state: cnt holds words remaining minus one, so cnt==0 marks the last word.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (bus.clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.burst_start) begin
            ptr_d   = bus.burst_addr;
            cnt_d   = bus.burst_len;
            state_d = BURST;
          end
        end
        BURST: begin
          if (bus.in_valid) begin
            ptr_d = ptr_q + 3'd1;
            if (cnt_q == 3'd0) begin
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Register writes and the done pulse; requests arriving during a burst are dropped.
  always_comb begin
    regs_d = regs_q;
    done_d = 1'b0;
    if (bus.clr) begin
      regs_d = '0;
    end else if (state_q == IDLE) begin
      if (bus.wr_en) begin
        regs_d[bus.wr_addr] = bus.wr_data;
      end
    end else if (bus.in_valid) begin
      regs_d[ptr_q] = bus.in_data;
      done_d        = (cnt_q == 3'd0);
    end
  end

  assign bus.q0         = regs_q[0];
  assign bus.q1         = regs_q[1];
  assign bus.q2         = regs_q[2];
  assign bus.q3         = regs_q[3];
  assign bus.q4         = regs_q[4];
  assign bus.q5         = regs_q[5];
  assign bus.q6         = regs_q[6];
  assign bus.q7         = regs_q[7];
  assign bus.busy       = (state_q == BURST);
  assign bus.burst_done = done_q;

endmodule

// File: tb/tb_banco_escritura.sv
// tb/tb_banco_escritura.sv - directed vector bench for banco_escritura
// Each vector is one clock of inputs plus the expected register image after that edge.
module tb_banco_escritura;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  banco_escritura_if #(.WIDTH(16)) bus ();
  banco_escritura #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic              clr;
    logic              we;
    logic [2:0]        wa;
    logic [15:0]       wd;
    logic              bs;
    logic [2:0]        ba;
    logic [2:0]        bl;
    logic              iv;
    logic [15:0]       id;
    logic [7:0][15:0]  eq;
    logic              busy;
    logic              done;
  } vec_t;

  vec_t             vq[$];
  logic [7:0][15:0] img;
  int               passed = 0;
  int               total  = 0;

  function automatic logic [7:0][15:0] q_now();
    logic [7:0][15:0] a;
    a[0] = bus.q0; a[1] = bus.q1; a[2] = bus.q2; a[3] = bus.q3;
    a[4] = bus.q4; a[5] = bus.q5; a[6] = bus.q6; a[7] = bus.q7;
    return a;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_all(input string nm, input logic [7:0][15:0] eq,
                           input logic eb, input logic ed);
    chk({nm, " q"}, q_now(), eq);
    chk({nm, " busy"}, {127'd0, bus.busy}, {127'd0, eb});
    chk({nm, " done"}, {127'd0, bus.burst_done}, {127'd0, ed});
  endtask

  task automatic add(input logic c, input logic we, input logic [2:0] wa,
                     input logic [15:0] wd, input logic bs, input logic [2:0] ba,
                     input logic [2:0] bl, input logic iv, input logic [15:0] id,
                     input logic eb, input logic ed);
    vec_t v;
    v.clr = c; v.we = we; v.wa = wa; v.wd = wd; v.bs = bs; v.ba = ba; v.bl = bl;
    v.iv = iv; v.id = id; v.eq = img; v.busy = eb; v.done = ed;
    vq.push_back(v);
  endtask

  task automatic drive(input logic c, input logic we, input logic [2:0] wa,
                       input logic [15:0] wd, input logic bs, input logic [2:0] ba,
                       input logic [2:0] bl, input logic iv, input logic [15:0] id);
    bus.clr = c; bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    bus.burst_start = bs; bus.burst_addr = ba; bus.burst_len = bl;
    bus.in_valid = iv; bus.in_data = id;
  endtask

  initial begin
    logic [2:0] idx;
    img = '0;
    // Reset and single write
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0);
    img[5] = 16'hBEEF;
    add(0, 1, 5, 16'hBEEF, 0, 0, 0, 0, 16'h0000, 0, 0);
    // Burst at 6, four words, wraps to 0 and 1
    add(0, 0, 0, 16'h0000, 1, 6, 3, 0, 16'h0000, 1, 0);
    img[6] = 16'h1111; add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h1111, 1, 0);
    img[7] = 16'h2222; add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h2222, 1, 0);
    img[0] = 16'h3333; add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h3333, 1, 0);
    img[1] = 16'h4444; add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h4444, 0, 1);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0);
    // Two-word burst at 2 with a three-cycle gap; writes and restarts in the gap are dropped
    add(0, 0, 0, 16'h0000, 1, 2, 1, 0, 16'h0000, 1, 0);
    img[2] = 16'h0202; add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0202, 1, 0);
    add(0, 1, 4, 16'hAAAA, 0, 0, 0, 0, 16'h0000, 1, 0);
    add(0, 1, 4, 16'hAAAA, 1, 7, 7, 0, 16'h0000, 1, 0);
    add(0, 1, 4, 16'hAAAA, 0, 0, 0, 0, 16'h0000, 1, 0);
    img[3] = 16'h0303; add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0303, 0, 1);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0);
    // Simultaneous single write and one-word burst at 0
    img[0] = 16'h5A5A; add(0, 1, 0, 16'h5A5A, 1, 0, 0, 0, 16'h0000, 1, 0);
    img[0] = 16'hC3C3; add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'hC3C3, 0, 1);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0);
    // Idle in_valid is ignored
    add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'hFFFF, 0, 0);
    // Back-to-back bursts: new start honoured in the done cycle
    add(0, 0, 0, 16'h0000, 1, 4, 0, 0, 16'h0000, 1, 0);
    img[4] = 16'h0444; add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0444, 0, 1);
    add(0, 0, 0, 16'h0000, 1, 5, 0, 0, 16'h0000, 1, 0);
    img[5] = 16'h0555; add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0555, 0, 1);
    // Eight-word burst starting at 3 covers every register once
    add(0, 0, 0, 16'h0000, 1, 3, 7, 0, 16'h0000, 1, 0);
    for (int k = 0; k < 8; k++) begin
      idx = 3'(3 + k);
      img[idx] = 16'h8000 + 16'(k);
      add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h8000 + 16'(k), k != 7, k == 7);
    end
    // Clear after the third word of an eight-word burst
    add(0, 0, 0, 16'h0000, 1, 0, 7, 0, 16'h0000, 1, 0);
    img[0] = 16'hD000; add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'hD000, 1, 0);
    img[1] = 16'hD001; add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'hD001, 1, 0);
    img[2] = 16'hD002; add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'hD002, 1, 0);
    img = '0;          add(1, 1, 6, 16'h6666, 1, 0, 0, 1, 16'hEEEE, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'hD003, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0);

    drive(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    #1 rst_n = 1'b0;
    #10;
    check_all("in_reset", '0, 0, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vq[i]) begin
      drive(vq[i].clr, vq[i].we, vq[i].wa, vq[i].wd, vq[i].bs,
            vq[i].ba, vq[i].bl, vq[i].iv, vq[i].id);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vq[i].eq, vq[i].busy, vq[i].done);
    end

    // Asynchronous reset between edges during a burst
    img = '0;
    drive(0, 0, 0, 16'h0000, 1, 1, 3, 0, 16'h0000);
    @(posedge clk); #1;
    drive(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h7777);
    @(posedge clk); #1;
    img[1] = 16'h7777;
    check_all("pre_arst", img, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check_all("arst_now", '0, 0, 0);
    #2 rst_n = 1'b1;
    img = '0;
    drive(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h9999);
    repeat (2) begin
      @(posedge clk); #1;
      check_all("post_arst_valid", img, 0, 0);
    end
    drive(0, 0, 0, 16'h0000, 1, 2, 0, 0, 16'h0000);
    @(posedge clk); #1;
    check_all("restart", img, 1, 0);
    drive(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h1234);
    @(posedge clk); #1;
    img[2] = 16'h1234;
    check_all("restart_word", img, 0, 1);
    drive(0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    @(posedge clk); #1;
    check_all("restart_idle", img, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/banco_escritura.md
# banco_escritura

Eight-entry, 16-bit register storage with write control for the register-bank datapath. Holds the register contents and drives them in parallel onto `q0`–`q7`, which feed the 8:1 read multiplexor directly. Accepts single-register writes, or an auto-incrementing burst load that fills consecutive registers from a streamed word source. Provides a synchronous clear.

## Interface
- `WIDTH`, 16, register and data width. It must match the read multiplexor's 16-bit inputs.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear of all registers. Aborts any burst.
- `wr_en`  in  1  single-write strobe. Honoured only in IDLE.
- `wr_addr`  in  3  single-write register index.
- `wr_data`  in  WIDTH  single-write data.
- `burst_start`  in  1  begin a burst load. Honoured only in IDLE.
- `burst_addr`  in  3  first register of the burst.
- `burst_len`  in  3  burst word count minus one (0 = 1 word, 7 = 8 words).
- `in_valid`  in  1  burst word present on `in_data`.
- `in_data`  in  WIDTH  burst word.
- `q0`..`q7`  out  WIDTH each  register contents, registered outputs.
- `busy`  out  1  high while in BURST.
- `burst_done`  out  1  one-cycle pulse after the last burst word is written.

## Operation
- **States:** IDLE and BURST.
- **Internal state:** 3-bit `ptr`; 3-bit `cnt` (words remaining minus one).

Priority per edge, highest first: `clr` > state action.
- **`clr` = 1:**
  - All eight registers are set to 0.
  - The state machine goes to IDLE.
  - `busy` is 0 in the following cycle.
  - No `burst_done` pulse is produced.
  - `wr_en`, `burst_start` and `in_valid` are ignored that cycle.
- **IDLE, `wr_en` = 1:** register[`wr_addr`] <= `wr_data`.
- **IDLE, `burst_start` = 1:**
  - Latch `ptr` <= `burst_addr` and `cnt` <= `burst_len`.
  - Go to BURST.
  - If `wr_en` is also high, the single write is performed on the same edge.
- **IDLE, `in_valid`:** ignored.
- **BURST, `in_valid` = 1:**
  - register[`ptr`] <= `in_data`.
  - `ptr` <= `ptr` + 1, modulo 8, so 7 wraps to 0.
  - If `cnt` == 0: go to IDLE and assert `burst_done` in the next cycle.
  - Otherwise `cnt` <= `cnt` − 1.
- **BURST, `in_valid` = 0:** hold all state; gaps of any length are allowed.
- **BURST:** `wr_en` and `burst_start` are ignored and dropped, not queued.
- **Burst length 8 (`burst_len` = 7):** every register is written exactly once, starting at `burst_addr` and wrapping.
- **Stale registers:** registers not addressed by a write hold their value indefinitely.
- **Asynchronous reset (`rst_n` low), at any time including mid-burst:**
  - All `q` = 0, `busy` = 0, `burst_done` = 0.
  - State = IDLE, `ptr` = 0, `cnt` = 0.
  - The burst is abandoned; no done pulse follows reset release.

## Timing
- **Write latency:** a write on edge N appears on the corresponding `q` output immediately after edge N (registered). The read multiplexor sees it in the same cycle, combinationally.
- **`busy`:** rises in the cycle after the `burst_start` edge. Falls in the cycle after the edge that writes the last word.
- **`burst_done`:** high for exactly the one cycle in which `busy` first reads 0.
- **Back-to-back bursts:** the earliest new `burst_start` is honoured in the `burst_done` cycle. That gives a one-cycle minimum gap between bursts.
- **Throughput:** one burst word per cycle while `in_valid` is held high. An L-word burst with continuous valid occupies L cycles of `busy`.
- **Outputs:** no combinational path from inputs to outputs.

## Test plan
- **Reset and single write:**
  - Release `rst_n` -> all `q` = 0x0000, `busy` = 0.
  - Then `wr_en` with `wr_addr` = 5, `wr_data` = 0xBEEF -> `q5` = 0xBEEF after the edge; the other registers stay 0.
- **Burst with wrap:**
  - `burst_start`, `burst_addr` = 6, `burst_len` = 3; data 0x1111, 0x2222, 0x3333, 0x4444 with continuous `in_valid`.
  - Result: `q6` = 0x1111, `q7` = 0x2222, `q0` = 0x3333, `q1` = 0x4444.
  - `busy` is high for 4 cycles; `burst_done` is high for 1 cycle.
- **Valid gaps and dropped writes:**
  - 2-word burst at address 2, with `in_valid` low for 3 cycles between the words and `wr_en` (addr 4, 0xAAAA) asserted during the gap.
  - Result: `q2`/`q3` are written; `q4` is unchanged; `busy` lasts 5 cycles.
- **Clear mid-burst:**
  - 8-word burst; assert `clr` after the 3rd word.
  - Result: all `q` = 0, `busy` = 0 next cycle, no `burst_done`.
  - A following `in_valid` word writes nothing.
- **Simultaneous start and write:**
  - In IDLE, `wr_en` (addr 0, 0x5A5A) and `burst_start` (addr 0, len 0) on the same edge, then word 0xC3C3.
  - Result: `q0` = 0x5A5A, then `q0` = 0xC3C3; `burst_done` pulses once.
- **Asynchronous reset mid-burst:**
  - Drop `rst_n` between clock edges during a burst.
  - Result: all outputs go to 0 immediately, without waiting for a clock edge.
  - After release, `in_valid` words are ignored until a new `burst_start`.
